// File: rtl/inequality_cmp_if.sv
// Sample/result bundle for inequality_cmp; hit_cnt exists only with INEQ_HITCNT_EN.
interface inequality_cmp_if;
  logic [3:0] num;
  logic       in_valid;
  logic [2:0] out;
  logic       out_valid;
`ifdef INEQ_HITCNT_EN
  logic [7:0] hit_cnt;
`endif

  modport master (
    output num, in_valid,
    input  out, out_valid
`ifdef INEQ_HITCNT_EN
    , input hit_cnt
`endif
  );

  modport slave (
    input  num, in_valid,
    output out, out_valid
`ifdef INEQ_HITCNT_EN
    , output hit_cnt
`endif
  );
endinterface

// File: rtl/inequality_cmp.sv
// Registered 4-bit unsigned {gt, lt, ne} flags against fixed thresholds; 1-cycle latency.
// No backpressure: every accepted sample yields a result. INEQ_HITCNT_EN adds a saturating gt counter.
module inequality_cmp #(
  parameter logic [3:0] HI_THR = 4'd5,
  parameter logic [3:0] LO_THR = 4'd4,
  parameter logic [3:0] EXCL   = 4'd0
) (
  input logic             clk,
  input logic             rst_n,
  inequality_cmp_if.slave bus
);

  logic gt_flag;
  logic lt_flag;
  logic ne_flag;

  always_comb begin
    gt_flag = (bus.num > HI_THR);
    lt_flag = (bus.num < LO_THR);
    ne_flag = (bus.num != EXCL);
  end

  // out holds its last value when no sample is accepted; only the valid pulse drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= 3'b000;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out <= {gt_flag, lt_flag, ne_flag};
      end
    end
  end

`ifdef INEQ_HITCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hit_cnt <= 8'd0;
    end else if (bus.in_valid && gt_flag && (bus.hit_cnt != 8'hff)) begin
      bus.hit_cnt <= bus.hit_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inequality_cmp.sv
// Directed bench for inequality_cmp: default thresholds plus a degenerate-threshold instance.
module tb_inequality_cmp;
  logic clk;
  logic rst_n;

  inequality_cmp_if bus_a ();
  inequality_cmp_if bus_b ();

  inequality_cmp dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  // HI_THR=15 and LO_THR=0 can never raise gt/lt.
  inequality_cmp #(.HI_THR(4'd15), .LO_THR(4'd0), .EXCL(4'd9)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] num;
    logic [2:0] exp_a;
    logic [2:0] exp_b;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] n);
    bus_a.in_valid = vld;
    bus_a.num      = n;
    bus_b.in_valid = vld;
    bus_b.num      = n;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  3'b010, 3'b001};
    vecs[1]  = '{4'd1,  3'b011, 3'b001};
    vecs[2]  = '{4'd2,  3'b011, 3'b001};
    vecs[3]  = '{4'd3,  3'b011, 3'b001};
    vecs[4]  = '{4'd4,  3'b001, 3'b001};
    vecs[5]  = '{4'd5,  3'b001, 3'b001};
    vecs[6]  = '{4'd6,  3'b101, 3'b001};
    vecs[7]  = '{4'd7,  3'b101, 3'b001};
    vecs[8]  = '{4'd8,  3'b101, 3'b001};
    vecs[9]  = '{4'd9,  3'b101, 3'b000};
    vecs[10] = '{4'd10, 3'b101, 3'b001};
    vecs[11] = '{4'd11, 3'b101, 3'b001};
    vecs[12] = '{4'd12, 3'b101, 3'b001};
    vecs[13] = '{4'd13, 3'b101, 3'b001};
    vecs[14] = '{4'd14, 3'b101, 3'b001};
    vecs[15] = '{4'd15, 3'b101, 3'b001};

    // Reset held with a live sample on the inputs.
    rst_n = 1'b0;
    drive(1'b1, 4'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_out", {5'd0, bus_a.out}, 8'h00);
      check("reset_vld", {7'd0, bus_a.out_valid}, 8'h00);
    end
`ifdef INEQ_HITCNT_EN
    check("reset_hitcnt", bus_a.hit_cnt, 8'd0);
`endif
    rst_n = 1'b1;

    // Single sample then idle.
    @(negedge clk);
    check("single_out", {5'd0, bus_a.out}, 8'h05);
    check("single_vld", {7'd0, bus_a.out_valid}, 8'h01);
    drive(1'b0, 4'd0);
    @(negedge clk);
    check("idle_vld", {7'd0, bus_a.out_valid}, 8'h00);
    check("idle_hold", {5'd0, bus_a.out}, 8'h05);

    // Back-to-back sweep.
    drive(1'b1, vecs[0].num);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("sweep_a_%0d", i), {5'd0, bus_a.out}, {5'd0, vecs[i].exp_a});
      check($sformatf("sweep_b_%0d", i), {5'd0, bus_b.out}, {5'd0, vecs[i].exp_b});
      check($sformatf("sweep_vld_%0d", i), {7'd0, bus_a.out_valid}, 8'h01);
      if (i < 15) drive(1'b1, vecs[i+1].num);
    end
    drive(1'b0, 4'd0);

    // Async reset between edges, with a sample pending at the next edge.
    drive(1'b1, 4'd7);
    @(negedge clk);
    check("pre_rst_out", {5'd0, bus_a.out}, 8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {5'd0, bus_a.out}, 8'h00);
    check("async_rst_vld", {7'd0, bus_a.out_valid}, 8'h00);
    @(negedge clk);
    check("rst_hold_out", {5'd0, bus_a.out}, 8'h00);
    drive(1'b0, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_vld", {7'd0, bus_a.out_valid}, 8'h00);
    check("post_rst_out", {5'd0, bus_a.out}, 8'h00);

`ifdef INEQ_HITCNT_EN
    check("hitcnt_cleared", bus_a.hit_cnt, 8'd0);
    drive(1'b1, 4'd15);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 2) check("hitcnt_3", bus_a.hit_cnt, 8'd3);
    end
    check("hitcnt_sat", bus_a.hit_cnt, 8'd255);
    drive(1'b1, 4'd2);
    @(negedge clk);
    check("hitcnt_hold", bus_a.hit_cnt, 8'd255);
    check("hitcnt_num2_out", {5'd0, bus_a.out}, 8'h03);
    drive(1'b0, 4'd0);
    rst_n = 1'b0;
    #1;
    check("hitcnt_rst", bus_a.hit_cnt, 8'd0);
    rst_n = 1'b1;
    // num==HI_THR must not count.
    drive(1'b1, 4'd5);
    @(negedge clk);
    check("hitcnt_boundary", bus_a.hit_cnt, 8'd0);
    drive(1'b0, 4'd0);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
